// File: rtl/sudoku_pkg.sv
// Shared constants, types and streamer state encoding for the sudoku board
// datapath (loader, store, streamer).
package sudoku_pkg;

   localparam int NUM_CELLS  = 81;
   localparam int ADDR_W     = 7;
   localparam int DIGIT_W    = 4;

   // Flag bit positions inside a streamed cell byte.
   localparam int FLAG_FIRST = 7;
   localparam int FLAG_LAST  = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_RD,
      ST_PRESENT,
      ST_RELEASE,
      ST_CSUM,
      ST_DONE
   } stream_state_t;

   typedef logic [DIGIT_W-1:0] cell_t;

endpackage

// File: rtl/sudoku_sync.sv
// Multi-flop synchronizer for a single asynchronous level input.
// Clears to 0 on reset so downstream logic sees a deasserted level.
module sudoku_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_ff;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[STAGES-2:0], d};
      end
   end

   assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/sudoku_board_streamer.sv
// Streams the board store back to the host: one flagged byte per cell over a
// four-phase req/ack handshake, optionally followed by an 8-bit checksum byte.
module sudoku_board_streamer
   import sudoku_pkg::*;
#(
   parameter int NUM_CELLS     = sudoku_pkg::NUM_CELLS,
   parameter int ADDR_W        = sudoku_pkg::ADDR_W,
   parameter int DIGIT_W       = sudoku_pkg::DIGIT_W,
   parameter bit SEND_CHECKSUM = 1'b1,
   parameter int SYNC_STAGES   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [DIGIT_W-1:0] rd_data,
   output logic [7:0]         out_data,
   output logic               out_req,
   input  logic               ack_in,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CELLS - 1);

   // Handshake: out_req rises only with ack_s low and out_data already stable;
   // the host raises ack once it has taken the byte, out_req then falls, and
   // the next byte may only be loaded after ack_s has returned low.
   stream_state_t     state;
   logic [ADDR_W-1:0] idx;
   logic [7:0]        sum;
   logic              rd_valid;
   logic              csum_sent;
   logic              ack_s;
   logic [7:0]        cell_byte;

   sudoku_sync #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack_in),
      .q   (ack_s)
   );

   always_comb begin
      cell_byte                = '0;
      cell_byte[DIGIT_W-1:0]   = rd_data;
      cell_byte[FLAG_FIRST]    = (idx == '0);
      cell_byte[FLAG_LAST]     = (idx == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         sum       <= '0;
         rd_valid  <= 1'b0;
         csum_sent <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         out_data  <= '0;
         out_req   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         rd_en    <= 1'b0;
         done     <= 1'b0;
         rd_valid <= rd_en;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  idx       <= '0;
                  sum       <= '0;
                  csum_sent <= 1'b0;
                  state     <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               rd_en   <= 1'b1;
               rd_addr <= idx;
               state   <= ST_WAIT_RD;
            end
            // rd_valid marks the cycle the store drives the requested cell.
            ST_WAIT_RD: begin
               if (rd_valid) begin
                  out_data <= cell_byte;
                  sum      <= sum + 8'(rd_data);
                  out_req  <= 1'b1;
                  state    <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (ack_s) begin
                  out_req <= 1'b0;
                  state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!ack_s) begin
                  if (csum_sent) begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else if (idx != LAST_IDX) begin
                     idx   <= idx + ADDR_W'(1);
                     state <= ST_FETCH;
                  end else if (SEND_CHECKSUM) begin
                     out_data  <= sum;
                     out_req   <= 1'b1;
                     csum_sent <= 1'b1;
                     state     <= ST_CSUM;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            ST_CSUM: begin
               if (ack_s) begin
                  out_req <= 1'b0;
                  state   <= ST_RELEASE;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sudoku_board_streamer.sv
// Bench for sudoku_board_streamer: a board store model, a host that acks
// each byte, and a scoreboard of bytes expected from the board contents.
module tb_sudoku_board_streamer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic       rd_en_a, rd_en_b;
   logic [6:0] rd_addr_a, rd_addr_b;
   logic [3:0] rd_data_a = '0;
   logic [3:0] rd_data_b = '0;
   logic [7:0] out_data_a, out_data_b;
   logic       out_req_a, out_req_b;
   logic       ack_a, ack_b;
   logic       busy_a, busy_b, done_a, done_b;

   logic       sel = 1'b0;
   logic       host_ack = 1'b0;
   int         ack_delay = 5;
   int         hold_cycles = 0;
   int         host_state = 0;
   int         host_cnt = 0;

   logic [3:0] mem [0:127];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   int         n_checks = 0;
   int         n_fail = 0;
   int         done_cnt = 0;
   int         stab_err = 0;
   int         ack_viol = 0;
   logic       prev_req = 1'b0;
   logic [7:0] prev_data = '0;

   logic       req_s, rd_en_s, busy_s, done_s;
   logic [7:0] data_s;
   logic [6:0] rd_addr_s;

   assign req_s     = sel ? out_req_b  : out_req_a;
   assign rd_en_s   = sel ? rd_en_b    : rd_en_a;
   assign busy_s    = sel ? busy_b     : busy_a;
   assign done_s    = sel ? done_b     : done_a;
   assign data_s    = sel ? out_data_b : out_data_a;
   assign rd_addr_s = sel ? rd_addr_b  : rd_addr_a;
   assign ack_a     = sel ? 1'b0 : host_ack;
   assign ack_b     = sel ? host_ack : 1'b0;

   sudoku_board_streamer u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_a),
      .rd_en    (rd_en_a),
      .rd_addr  (rd_addr_a),
      .rd_data  (rd_data_a),
      .out_data (out_data_a),
      .out_req  (out_req_a),
      .ack_in   (ack_a),
      .busy     (busy_a),
      .done     (done_a)
   );

   sudoku_board_streamer #(
      .NUM_CELLS     (4),
      .SEND_CHECKSUM (1'b0)
   ) u_dut_small (
      .clk      (clk),
      .rst      (rst),
      .start    (start_b),
      .rd_en    (rd_en_b),
      .rd_addr  (rd_addr_b),
      .rd_data  (rd_data_b),
      .out_data (out_data_b),
      .out_req  (out_req_b),
      .ack_in   (ack_b),
      .busy     (busy_b),
      .done     (done_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // board store with one-cycle read latency
   always @(posedge clk) begin
      if (rd_en_a) rd_data_a <= mem[rd_addr_a];
      if (rd_en_b) rd_data_b <= mem[rd_addr_b];
   end

   // host: waits ack_delay cycles after req, takes the byte, holds ack
   // for hold_cycles after req falls
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            host_ack   = 1'b0;
            host_state = 0;
            host_cnt   = 0;
         end else begin
            case (host_state)
               0: if (req_s) begin host_cnt = 0; host_state = 1; end
               1: begin
                  if (host_cnt >= ack_delay) begin
                     rx_q.push_back(data_s);
                     host_ack   = 1'b1;
                     host_state = 2;
                  end else begin
                     host_cnt++;
                  end
               end
               2: if (!req_s) begin host_cnt = 0; host_state = 3; end
               3: begin
                  if (host_cnt >= hold_cycles) begin
                     host_ack   = 1'b0;
                     host_state = 0;
                  end else begin
                     host_cnt++;
                  end
               end
               default: host_state = 0;
            endcase
         end
      end
   end

   // protocol monitor
   always @(negedge clk) begin
      if (rst) begin
         prev_req <= 1'b0;
      end else begin
         if (req_s && prev_req && (data_s != prev_data)) stab_err <= stab_err + 1;
         if (rd_en_s && host_ack) ack_viol <= ack_viol + 1;
         if (done_s) done_cnt <= done_cnt + 1;
         prev_req  <= req_s;
         prev_data <= data_s;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic pulse_start(input bit use_b, input bit val);
      if (use_b) start_b = val;
      else       start_a = val;
   endtask

   // drive one full stream and score it against the board contents
   task automatic run_stream(input int n, input bit use_b, input bit with_csum, input bit poke);
      int         cyc;
      int         sum;
      int         first_req;
      int         first_addr;
      bit         late;
      logic [7:0] b;
      sel = use_b;
      rx_q.delete();
      exp_q.delete();
      sum = 0;
      for (int i = 0; i < n; i++) begin
         b = 8'(mem[i]);
         if (i == 0)     b = b | 8'h80;
         if (i == n - 1) b = b | 8'h40;
         exp_q.push_back(b);
         sum += int'(mem[i]);
      end
      if (with_csum) exp_q.push_back(8'(sum % 256));
      @(negedge clk);
      done_cnt = 0;
      stab_err = 0;
      ack_viol = 0;
      pulse_start(use_b, 1'b1);
      @(negedge clk);
      pulse_start(use_b, 1'b0);
      check_eq("busy_accept", busy_s, 1);
      cyc        = 0;
      first_req  = -1;
      first_addr = -1;
      while (!done_s && cyc < 30000) begin
         if (req_s && first_req < 0) first_req = cyc;
         if (rd_en_s && first_addr < 0) first_addr = int'(rd_addr_s);
         pulse_start(use_b, poke && rd_en_s && (rd_addr_s == 7'd10 || rd_addr_s == 7'd50));
         @(negedge clk);
         cyc++;
      end
      pulse_start(use_b, 1'b0);
      check_eq("done_seen", done_s, 1);
      check_eq("busy_at_done", busy_s, 1);
      check_eq("req_latency", first_req, 3);
      check_eq("first_addr", first_addr, 0);
      pulse_start(use_b, 1'b1);
      @(negedge clk);
      pulse_start(use_b, 1'b0);
      check_eq("busy_after_done", busy_s, 0);
      late = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy_s || rd_en_s) late = 1'b1;
      end
      check_eq("start_in_done_ignored", late, 0);
      check_eq("done_count", done_cnt, 1);
      check_eq("out_data_stable", stab_err, 0);
      check_eq("no_fetch_under_ack", ack_viol, 0);
      check_eq("byte_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check_eq($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
   endtask

   initial begin
      int         cyc;
      bit         found;
      logic [7:0] last_b;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_req_a",   out_req_a,  0);
      check_eq("rst_busy_a",  busy_a,     0);
      check_eq("rst_done_a",  done_a,     0);
      check_eq("rst_rden_a",  rd_en_a,    0);
      check_eq("rst_data_a",  out_data_a, 0);
      check_eq("rst_addr_a",  rd_addr_a,  0);
      check_eq("rst_req_b",   out_req_b,  0);
      check_eq("rst_busy_b",  busy_b,     0);
      rst = 1'b0;

      // cell i = i mod 10, slow host
      for (int i = 0; i < 128; i++) mem[i] = 4'(i % 10);
      ack_delay = 5;
      run_stream(81, 1'b0, 1'b1, 1'b0);
      check_eq("mod10_byte0", rx_q[0], 8'h80);
      check_eq("mod10_byte1", rx_q[1], 8'h01);
      check_eq("mod10_byte80", rx_q[80], 8'h40);
      check_eq("mod10_csum", rx_q[81], 8'h68);

      // all nines: checksum wraps
      for (int i = 0; i < 128; i++) mem[i] = 4'd9;
      ack_delay = $urandom_range(0, 3);
      run_stream(81, 1'b0, 1'b1, 1'b0);
      check_eq("nine_byte0", rx_q[0], 8'h89);
      check_eq("nine_byte1", rx_q[1], 8'h09);
      check_eq("nine_byte80", rx_q[80], 8'h49);
      check_eq("nine_csum", rx_q[81], 8'hD9);

      // random contents including out-of-range digits, extra starts while busy
      for (int i = 0; i < 128; i++) mem[i] = 4'($urandom_range(0, 15));
      ack_delay = $urandom_range(0, 4);
      run_stream(81, 1'b0, 1'b1, 1'b1);

      // host keeps ack high long after req falls
      for (int i = 0; i < 128; i++) mem[i] = 4'($urandom_range(0, 9));
      ack_delay   = $urandom_range(0, 2);
      hold_cycles = 20;
      run_stream(81, 1'b0, 1'b1, 1'b0);
      hold_cycles = 0;

      // reset while cell 40 is presented
      sel       = 1'b0;
      ack_delay = 5;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc   = 0;
      found = 1'b0;
      while (!found && cyc < 20000) begin
         if (out_req_a && rd_addr_a == 7'd40) found = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check_eq("reached_cell40", found, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("midrst_req", out_req_a, 0);
      check_eq("midrst_busy", busy_a, 0);
      check_eq("midrst_done", done_a, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 4'($urandom_range(0, 9));
      run_stream(81, 1'b0, 1'b1, 1'b0);

      // four-cell instance without checksum
      for (int i = 0; i < 128; i++) mem[i] = 4'($urandom_range(0, 9));
      ack_delay = 1;
      run_stream(4, 1'b1, 1'b0, 1'b0);
      last_b = rx_q[3];
      check_eq("small_last_flag", last_b[6], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
